// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ctrl_state_e;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: ID reads a register that the load in EX has not yet returned.
module hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit_s = id_use_rs2 & (id_rs2 == ex_rd);
  // x0 is hardwired, so a load targeting it never creates a dependency
  assign load_use  = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer: freezes, redirect flushes, load-use interlocks
// and a counted drain ahead of serializing instructions, plus stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_serialize,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ctrl_drain,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned      DC_W       = $clog2(DRAIN_CYCLES);
  localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);
  localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  ctrl_state_e      state_r;
  ctrl_state_e      state_nxt_s;
  logic [DC_W-1:0]  drain_cnt_r;
  logic [DC_W-1:0]  drain_cnt_nxt_s;
  logic             ser_done_r;
  logic             ser_done_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_inc_s;
  logic             flush_inc_s;
  logic             load_use_s;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use_s)
  );

  // Priority decision: enables, flushes, next state and counter strobes
  always_comb begin
    pc_en           = 1'b1;
    if_id_en        = 1'b1;
    id_ex_en        = 1'b1;
    ex_mem_en       = 1'b1;
    mem_wb_en       = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    ser_done_nxt_s  = ser_done_r;
    stall_inc_s     = 1'b0;
    flush_inc_s     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      stall_inc_s = 1'b1;
    end else if (ex_valid & ex_redirect) begin
      // squashes ID, so any drain in progress belongs to a dead instruction
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      state_nxt_s     = RUN;
      drain_cnt_nxt_s = {DC_W{1'b0}};
      ser_done_nxt_s  = 1'b0;
      flush_inc_s     = 1'b1;
    end else if (state_r == DRAIN) begin
      pc_en           = 1'b0;
      if_id_en        = 1'b0;
      id_ex_flush     = 1'b1;
      stall_inc_s     = 1'b1;
      drain_cnt_nxt_s = drain_cnt_r - DC_W'(1);
      if (drain_cnt_r == DRAIN_LAST) begin
        state_nxt_s    = RUN;
        ser_done_nxt_s = 1'b1;
      end else begin
        state_nxt_s    = DRAIN;
      end
    end else if (load_use_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc_s = 1'b1;
    end else if (id_valid & id_serialize & ~ser_done_r) begin
      pc_en           = 1'b0;
      if_id_en        = 1'b0;
      id_ex_flush     = 1'b1;
      stall_inc_s     = 1'b1;
      state_nxt_s     = DRAIN;
      drain_cnt_nxt_s = DRAIN_LOAD;
    end else begin
      ser_done_nxt_s = 1'b0;
    end
  end

  // State, drain counter, serialize flag and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      drain_cnt_r <= {DC_W{1'b0}};
      ser_done_r  <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      ser_done_r  <= ser_done_nxt_s;
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign ctrl_drain = (state_r == DRAIN);
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int DC = 3;

  logic clk;
  logic rst;
  logic id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic id_use_rs1;
  logic id_use_rs2;
  logic id_serialize;
  logic ex_valid;
  logic ex_mem_read;
  logic [4:0] ex_rd;
  logic ex_redirect;
  logic mem_busy;

  logic a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic a_if_id_flush, a_id_ex_flush, a_ctrl_drain;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic b_if_id_flush, b_id_ex_flush, b_ctrl_drain;
  logic [3:0] b_stall_cnt, b_flush_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic started = 1'b0;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_serialize(id_serialize),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .ctrl_drain(a_ctrl_drain), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_serialize(id_serialize),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .ctrl_drain(b_ctrl_drain), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output bundles ordered {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  logic [6:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush};
  assign b_ctl = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush};

  // Behavioural model: bubbles still owed to a pending serializer, whether it
  // already got them, and plain unbounded event tallies.
  int   m_owed = 0;
  bit   m_ser_ok = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;
  int   exp_kind;
  logic exp_lu;
  logic [6:0] exp_ctl;

  always_comb begin
    exp_kind = 6;
    exp_ctl  = 7'b1111100;
    exp_lu   = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    if (rst)                                         exp_kind = 0;
    else if (mem_busy)                               exp_kind = 1;
    else if (ex_valid && ex_redirect)                exp_kind = 2;
    else if (m_owed > 0)                             exp_kind = 3;
    else if (exp_lu)                                 exp_kind = 4;
    else if (id_valid && id_serialize && !m_ser_ok)  exp_kind = 5;
    else                                             exp_kind = 6;
    case (exp_kind)
      0:       exp_ctl = 7'b0000011;
      1:       exp_ctl = 7'b0000000;
      2:       exp_ctl = 7'b1111111;
      3, 4, 5: exp_ctl = 7'b0011101;
      default: exp_ctl = 7'b1111100;
    endcase
  end

  always @(posedge clk) begin
    case (exp_kind)
      0: begin m_owed <= 0; m_ser_ok <= 1'b0; m_stall <= 0; m_flush <= 0; end
      1: m_stall <= m_stall + 1;
      2: begin m_owed <= 0; m_ser_ok <= 1'b0; m_flush <= m_flush + 1; end
      3: begin
        m_stall <= m_stall + 1;
        m_owed  <= m_owed - 1;
        if (m_owed == 1) m_ser_ok <= 1'b1;
      end
      4: m_stall <= m_stall + 1;
      5: begin m_stall <= m_stall + 1; m_owed <= DC - 1; end
      default: m_ser_ok <= 1'b0;
    endcase
  end

  function automatic logic [31:0] sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      chk("ctl16", {25'd0, a_ctl}, {25'd0, exp_ctl});
      chk("ctl4", {25'd0, b_ctl}, {25'd0, exp_ctl});
      chk("drain16", {31'd0, a_ctrl_drain}, {31'd0, (m_owed != 0)});
      chk("drain4", {31'd0, b_ctrl_drain}, {31'd0, (m_owed != 0)});
      chk("stall16", {16'd0, a_stall_cnt}, sat(m_stall, 16));
      chk("flush16", {16'd0, a_flush_cnt}, sat(m_flush, 16));
      chk("stall4", {28'd0, b_stall_cnt}, sat(m_stall, 4));
      chk("flush4", {28'd0, b_flush_cnt}, sat(m_flush, 4));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nb();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_serialize = 1'b0; ex_valid = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd3;
    ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    started = 1'b1;
    nb();
    chk("rst_pc_en", {31'd0, a_pc_en}, 32'd0);
    chk("rst_flushes", {30'd0, a_if_id_flush, a_id_ex_flush}, 32'd3);
    cyc();
    nb();
    chk("rst_drain", {31'd0, a_ctrl_drain}, 32'd0);
    chk("rst_stall", {16'd0, a_stall_cnt}, 32'd0);
    chk("rst_flushcnt", {16'd0, a_flush_cnt}, 32'd0);
    cyc();

    // load-use interlock
    do_reset(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    nb();
    chk("lu_pc_en", {31'd0, a_pc_en}, 32'd0);
    chk("lu_if_id_en", {31'd0, a_if_id_en}, 32'd0);
    chk("lu_id_ex_flush", {31'd0, a_id_ex_flush}, 32'd1);
    chk("lu_stall_pre", {16'd0, a_stall_cnt}, 32'd0);
    cyc(); idle();
    nb();
    chk("lu_stall_post", {16'd0, a_stall_cnt}, 32'd1);
    chk("lu_release", {25'd0, a_ctl}, 32'h7C);
    cyc();

    // no false interlock: x0 destination, then rs1 not used
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    nb();
    chk("nfi_rd0", {25'd0, a_ctl}, 32'h7C);
    cyc();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    nb();
    chk("nfi_nouse", {25'd0, a_ctl}, 32'h7C);
    cyc(); idle();
    nb();
    chk("nfi_stall", {16'd0, a_stall_cnt}, 32'd1);
    cyc();

    // serialize with id_serialize held
    do_reset(); idle();
    id_serialize = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      nb();
      chk("ser_pc_en", {31'd0, a_pc_en}, (i == 4) ? 32'd1 : 32'd0);
      chk("ser_drain", {31'd0, a_ctrl_drain}, (i == 2 || i == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    id_serialize = 1'b0;
    nb();
    chk("ser_stall", {16'd0, a_stall_cnt}, 32'd3);
    cyc();

    // redirect on bubble 2
    do_reset(); idle();
    id_serialize = 1'b1;
    nb(); cyc();
    ex_redirect = 1'b1;
    nb();
    chk("rd_drain_in", {31'd0, a_ctrl_drain}, 32'd1);
    chk("rd_ctl", {25'd0, a_ctl}, 32'h7F);
    cyc();
    ex_redirect = 1'b0; id_serialize = 1'b0;
    nb();
    chk("rd_drain_out", {31'd0, a_ctrl_drain}, 32'd0);
    chk("rd_flushcnt", {16'd0, a_flush_cnt}, 32'd1);
    cyc();

    // freeze inside a drain
    do_reset(); idle();
    id_serialize = 1'b1;
    nb(); cyc();
    mem_busy = 1'b1;
    repeat (4) begin
      nb();
      chk("frz_ctl", {25'd0, a_ctl}, 32'h00);
      cyc();
    end
    mem_busy = 1'b0;
    repeat (2) begin
      nb();
      chk("frz_bubble", {25'd0, a_ctl}, 32'h1D);
      cyc();
    end
    nb();
    chk("frz_issue", {31'd0, a_pc_en}, 32'd1);
    chk("frz_stall", {16'd0, a_stall_cnt}, 32'd7);
    cyc();
    id_serialize = 1'b0;

    // reset mid-drain restarts a full drain
    do_reset(); idle();
    id_serialize = 1'b1;
    nb(); cyc();
    rst = 1'b1;
    nb();
    chk("rmd_ctl", {25'd0, a_ctl}, 32'h03);
    cyc();
    rst = 1'b0;
    nb();
    chk("rmd_drain", {31'd0, a_ctrl_drain}, 32'd0);
    chk("rmd_stall", {16'd0, a_stall_cnt}, 32'd0);
    chk("rmd_restart", {31'd0, a_pc_en}, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      nb();
      chk("rmd_seq", {31'd0, a_ctrl_drain}, (i < 2) ? 32'd1 : 32'd0);
      cyc();
    end
    id_serialize = 1'b0;

    // saturation of the 4-bit instance
    do_reset(); idle();
    mem_busy = 1'b1;
    repeat (20) cyc();
    mem_busy = 1'b0;
    nb();
    chk("sat_w4", {28'd0, b_stall_cnt}, 32'd15);
    chk("sat_w16", {16'd0, a_stall_cnt}, 32'd20);
    cyc();
    mem_busy = 1'b1;
    cyc();
    mem_busy = 1'b0;
    nb();
    chk("sat_hold", {28'd0, b_stall_cnt}, 32'd15);
    cyc();

    // randomized traffic
    repeat (3000) begin
      rst          = ($urandom_range(63) == 0);
      mem_busy     = ($urandom_range(5) == 0);
      ex_valid     = ($urandom_range(3) != 0);
      ex_redirect  = ($urandom_range(7) == 0);
      ex_mem_read  = ($urandom_range(2) == 0);
      ex_rd        = 5'($urandom_range(3));
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      id_use_rs1   = 1'($urandom_range(1));
      id_use_rs2   = 1'($urandom_range(1));
      id_valid     = ($urandom_range(4) != 0);
      id_serialize = ($urandom_range(5) == 0);
      cyc();
    end

    idle();
    rst = 1'b0;
    nb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
